// File: rtl/sample_fifo.sv
// Single-clock sample FIFO between the sample source and the FIR datapath.
// Circular RAM with binary pointers, occupancy counter and registered read data.
module sample_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_en,
  output logic                  empty
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered occupancy count directly.
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));

  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Storage array is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo: reset, ordering, full/empty
// boundaries, simultaneous access, pointer wrap and asynchronous reset.
module tb_sample_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        full;
  logic [15:0] rd_data;
  logic        rd_en;
  logic        empty;

  int unsigned n_pass;
  int unsigned n_total;

  sample_fifo #(
    .DATA_WIDTH(16),
    .DEPTH     (16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_data(wr_data),
    .wr_en  (wr_en),
    .full   (full),
    .rd_data(rd_data),
    .rd_en  (rd_en),
    .empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1ns after it for sampling and driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 16'h0000;
    repeat (3) step();
    n_total++;
    if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else n_pass++;
    n_total++;
    if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
    n_total++;
    if (rd_data !== 16'h0000) $display("FAIL reset_rd_data got=%h exp=0000", rd_data); else n_pass++;
    rst = 1'b1;
    repeat (2) step();
    n_total++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL reset_release_flags got empty=%b full=%b exp empty=1 full=0", empty, full);
    else n_pass++;
  endtask

  task automatic test_basic_order();
    logic [15:0] exp;
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      step();
      n_total++;
      if (empty !== 1'b0 || full !== 1'b0)
        $display("FAIL order_wr_flags[%0d] got empty=%b full=%b exp empty=0 full=0", i, empty, full);
      else n_pass++;
    end
    wr_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      rd_en = 1'b1;
      step();
      exp = 16'(i);
      n_total++;
      if (rd_data !== exp) $display("FAIL order_rd[%0d] got=%h exp=%h", i, rd_data, exp); else n_pass++;
    end
    rd_en = 1'b0;
    n_total++;
    if (empty !== 1'b1) $display("FAIL order_empty_after got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h0005) $display("FAIL underflow_rd_hold got=%h exp=0005", rd_data); else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL underflow_empty got=%b exp=1", empty); else n_pass++;
    wr_en = 1'b1; wr_data = 16'h0042;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h0042) $display("FAIL underflow_recover got=%h exp=0042", rd_data); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
      step();
      if (i == 14) begin
        n_total++;
        if (full !== 1'b0) $display("FAIL fill_full_at15 got=%b exp=0", full); else n_pass++;
      end
    end
    n_total++;
    if (full !== 1'b1) $display("FAIL fill_full_at16 got=%b exp=1", full); else n_pass++;
    wr_data = 16'hDEAD;
    step();
    wr_en = 1'b0;
    n_total++;
    if (full !== 1'b1) $display("FAIL overflow_full got=%b exp=1", full); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      exp = 16'h0100 + 16'(i);
      n_total++;
      if (rd_data !== exp) $display("FAIL drain_rd[%0d] got=%h exp=%h", i, rd_data, exp); else n_pass++;
    end
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h010F || empty !== 1'b1)
      $display("FAIL overflow_discard got rd=%h empty=%b exp rd=010F empty=1", rd_data, empty);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 16'h0200 + 16'(i);
      step();
    end
    wr_data = 16'hBEEF; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_total++;
    if (full !== 1'b1) $display("FAIL simul_full_stays got=%b exp=1", full); else n_pass++;
    n_total++;
    if (rd_data !== 16'h0200) $display("FAIL simul_full_oldest got=%h exp=0200", rd_data); else n_pass++;
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      exp = (i == 16) ? 16'hBEEF : 16'h0200 + 16'(i);
      n_total++;
      if (rd_data !== exp) $display("FAIL simul_drain[%0d] got=%h exp=%h", i, rd_data, exp); else n_pass++;
    end
    rd_en = 1'b0;
    n_total++;
    if (empty !== 1'b1) $display("FAIL simul_drain_empty got=%b exp=1", empty); else n_pass++;
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'h0033;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    n_total++;
    if (empty !== 1'b0 || full !== 1'b0)
      $display("FAIL simul_empty_flags got empty=%b full=%b exp empty=0 full=0", empty, full);
    else n_pass++;
    n_total++;
    if (rd_data !== 16'hBEEF) $display("FAIL simul_empty_no_fallthru got=%h exp=beef", rd_data); else n_pass++;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h0033 || empty !== 1'b1)
      $display("FAIL simul_empty_read got rd=%h empty=%b exp rd=0033 empty=1", rd_data, empty);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int          occ;
    int          wr_idx;
    int          rd_idx;
    bit          do_wr;
    bit          do_rd;
    logic [15:0] exp;
    occ = 0; wr_idx = 0; rd_idx = 0;
    for (int c = 0; c < 200 && rd_idx < 40; c++) begin
      do_wr   = (wr_idx < 40);
      do_rd   = (occ > 0) && ((c % 4 != 0) || (wr_idx >= 40));
      wr_en   = do_wr;
      wr_data = 16'h0300 + 16'(wr_idx);
      rd_en   = do_rd;
      step();
      if (do_wr) begin
        wr_idx++; occ++;
      end
      if (do_rd) begin
        exp = 16'h0300 + 16'(rd_idx);
        n_total++;
        if (rd_data !== exp) $display("FAIL wrap_rd[%0d] got=%h exp=%h", rd_idx, rd_data, exp); else n_pass++;
        rd_idx++; occ--;
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    n_total++;
    if (rd_idx != 40) $display("FAIL wrap_timeout got=%0d reads exp=40", rd_idx); else n_pass++;
    n_total++;
    if (empty !== 1'b1) $display("FAIL wrap_empty_end got=%b exp=1", empty); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'h0400 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL async_rst_flags got empty=%b full=%b exp empty=1 full=0", empty, full);
    else n_pass++;
    n_total++;
    if (rd_data !== 16'h0000) $display("FAIL async_rst_rd_data got=%h exp=0000", rd_data); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h0000 || empty !== 1'b1)
      $display("FAIL async_rst_discard got rd=%h empty=%b exp rd=0000 empty=1", rd_data, empty);
    else n_pass++;
    wr_en = 1'b1; wr_data = 16'h0055;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    n_total++;
    if (rd_data !== 16'h0055) $display("FAIL async_rst_fresh got=%h exp=0055", rd_data); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic_order();
    test_underflow();
    test_fill_overflow();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
